// File: rtl/led_pattern_gen.sv
// LED pattern generator: divides clk into pattern steps and drives an
// active-low LED bank with one of four patterns (fill/bounce, chase, scan,
// blink). A mode change restarts the pattern from step 0.
// Optional feature: define LED_PATTERN_PWM_EN to add a 4-bit brightness input
// that gates lit LEDs with a free-running 4-bit PWM counter.
module led_pattern_gen #(
  parameter int N_LEDS   = 4,
  parameter int TICK_DIV = 25000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
`ifdef LED_PATTERN_PWM_EN
  input  logic [3:0]        brightness,
`endif
  output logic [N_LEDS-1:0] LEDs,
  output logic              step_strobe
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = $clog2(2 * N_LEDS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  localparam logic [1:0] MODE_FILL  = 2'd0;
  localparam logic [1:0] MODE_CHASE = 2'd1;
  localparam logic [1:0] MODE_SCAN  = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;

  logic [DIV_W-1:0]  div_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [1:0]        mode_reg;
  logic [IDX_W-1:0]  idx_eff;
  logic [IDX_W-1:0]  idx_next;
  logic [N_LEDS-1:0] lit;
  logic [N_LEDS-1:0] drive;
  logic              tick;
  logic              mode_change;
  int                step_count;

  assign tick        = en && (div_reg == DIV_LAST);
  assign mode_change = (mode != mode_reg);

  // Step count of the registered mode, range-guarded index and its successor
  always_comb begin
    case (mode_reg)
      MODE_FILL:  step_count = 2 * N_LEDS;
      MODE_CHASE: step_count = N_LEDS;
      MODE_SCAN:  step_count = 2 * N_LEDS - 2;
      default:    step_count = 2;
    endcase
    idx_eff  = (int'(idx_reg) < step_count) ? idx_reg : '0;
    idx_next = (int'(idx_eff) == step_count - 1) ? '0 : idx_eff + IDX_W'(1);
  end

  // Decode (registered mode, step) into an active-high "lit" vector
  always_comb begin
    int i_eff;
    int k;
    int pos;
    i_eff = int'(idx_eff);
    // k = number of LEDs lit in fill/bounce; pos = lit position in scan
    k     = (i_eff < N_LEDS) ? i_eff + 1 : 2 * N_LEDS - 1 - i_eff;
    pos   = (i_eff < N_LEDS) ? i_eff : 2 * N_LEDS - 2 - i_eff;
    lit   = '0;
    for (int b = 0; b < N_LEDS; b++) begin
      case (mode_reg)
        MODE_FILL:  lit[b] = (b < k);
        MODE_CHASE: lit[b] = (b == i_eff);
        MODE_SCAN:  lit[b] = (b == pos);
        default:    lit[b] = (i_eff == 0);
      endcase
    end
  end

`ifdef LED_PATTERN_PWM_EN
  logic [3:0] pwm_reg;

  // Free-running PWM counter; lit LEDs are only driven while it is below brightness
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_reg <= 4'd0;
    else        pwm_reg <= pwm_reg + 4'd1;
  end

  assign drive = ~(lit & {N_LEDS{pwm_reg < brightness}});
`else
  assign drive = ~lit;
`endif

  // Divider, step index, mode history, strobe and registered LED drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg     <= '0;
      idx_reg     <= '0;
      mode_reg    <= MODE_FILL;
      LEDs        <= '1;
      step_strobe <= 1'b0;
    end else begin
      mode_reg <= mode;
      LEDs     <= drive;
      if (mode_change) begin
        // Restart the new pattern; this outranks a coincident tick
        div_reg     <= '0;
        idx_reg     <= '0;
        step_strobe <= 1'b0;
      end else if (tick) begin
        div_reg     <= '0;
        idx_reg     <= idx_next;
        step_strobe <= 1'b1;
      end else begin
        step_strobe <= 1'b0;
        if (en) div_reg <= div_reg + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (default build, PWM feature off).
// Two instances: N_LEDS=4/TICK_DIV=4 and N_LEDS=5/TICK_DIV=2, compared each
// cycle against a reference model built from pattern lists.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [1:0] mode5 = 2'd2;
  logic [3:0] leds4;
  logic [4:0] leds5;
  logic       stb4, stb5;
`ifdef LED_PATTERN_PWM_EN
  logic [3:0] brightness = 4'd15;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  led_pattern_gen #(.N_LEDS(4), .TICK_DIV(4)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
`ifdef LED_PATTERN_PWM_EN
    .brightness(brightness),
`endif
    .LEDs(leds4), .step_strobe(stb4)
  );

  led_pattern_gen #(.N_LEDS(5), .TICK_DIV(2)) u5 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode5),
`ifdef LED_PATTERN_PWM_EN
    .brightness(brightness),
`endif
    .LEDs(leds5), .step_strobe(stb5)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int     div;
    int     idx;
    int     mreg;
    longint leds;
    bit     strobe;
  } model_t;

  model_t m4, m5;

  function automatic longint full_mask(int n);
    return (longint'(1) << n) - 1;
  endfunction

  // Lit mask for step idx of a mode, built as an explicit list of steps
  function automatic longint pat_lit(int md, int n, int idx, output int len);
    longint q[$];
    int     i;
    case (md)
      0: begin
        for (int k = 1; k <= n; k++)      q.push_back((longint'(1) << k) - 1);
        for (int k = n - 1; k >= 0; k--)  q.push_back((longint'(1) << k) - 1);
      end
      1: for (int p = 0; p < n; p++)      q.push_back(longint'(1) << p);
      2: begin
        for (int p = 0; p < n; p++)       q.push_back(longint'(1) << p);
        for (int p = n - 2; p >= 1; p--)  q.push_back(longint'(1) << p);
      end
      default: begin
        q.push_back(full_mask(n));
        q.push_back(0);
      end
    endcase
    len = q.size();
    i = (idx < 0 || idx >= len) ? 0 : idx;
    return q[i];
  endfunction

  function automatic model_t model_reset(int n);
    model_t r;
    r.div = 0; r.idx = 0; r.mreg = 0; r.strobe = 1'b0;
    r.leds = full_mask(n);
    return r;
  endfunction

  function automatic model_t model_edge(model_t m, int n, int d, bit e, int md);
    model_t r;
    int     len;
    longint l;
    r = m;
    l = pat_lit(m.mreg, n, m.idx, len);
    r.leds = ~l & full_mask(n);
    if (md != m.mreg) begin
      r.idx = 0; r.div = 0; r.strobe = 1'b0;
    end else if (e && m.div == d - 1) begin
      r.div = 0; r.idx = (m.idx + 1) % len; r.strobe = 1'b1;
    end else begin
      r.strobe = 1'b0;
      if (e) r.div = m.div + 1;
    end
    r.mreg = md;
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance models at the edge, compare both DUTs 1 time unit later
  task automatic cyc();
    @(posedge clk);
    m4 = model_edge(m4, 4, 4, en, int'(mode));
    m5 = model_edge(m5, 5, 2, en, int'(mode5));
    #1;
    check("model_leds4", longint'(leds4), m4.leds);
    check("model_stb4",  longint'(stb4),  longint'(m4.strobe));
    check("model_leds5", longint'(leds5), m5.leds);
    check("model_stb5",  longint'(stb5),  longint'(m5.strobe));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m4 = model_reset(4);
    m5 = model_reset(5);
    repeat (2) @(posedge clk);
    #1;
    check("reset_leds4", longint'(leds4), 64'hF);
    check("reset_stb4",  longint'(stb4),  0);
    check("reset_leds5", longint'(leds5), 64'h1F);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    bit         en;
    logic [1:0] mode;
    logic [3:0] leds;
    int         hold;
  } vec_t;

  vec_t       tbl[10];
  logic [4:0] scan5_exp[9];
  logic [4:0] seen5[$];

  initial begin
    logic [3:0] held;
    bit         found;

    tbl[0] = '{1'b1, 2'd0, 4'b1110, 4};
    tbl[1] = '{1'b1, 2'd0, 4'b1100, 4};
    tbl[2] = '{1'b1, 2'd0, 4'b1000, 4};
    tbl[3] = '{1'b1, 2'd0, 4'b0000, 4};
    tbl[4] = '{1'b1, 2'd0, 4'b1000, 4};
    tbl[5] = '{1'b1, 2'd0, 4'b1100, 4};
    tbl[6] = '{1'b1, 2'd0, 4'b1110, 4};
    tbl[7] = '{1'b1, 2'd0, 4'b1111, 4};
    tbl[8] = '{1'b1, 2'd0, 4'b1110, 4};
    tbl[9] = '{1'b1, 2'd0, 4'b1100, 4};
    scan5_exp = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111,
                  5'b10111, 5'b11011, 5'b11101, 5'b11110};

    // Fill/bounce sequence from reset, each pattern held TICK_DIV cycles
    en = 1'b1; mode = 2'd0; mode5 = 2'd2;
    do_reset();
    for (int v = 0; v < 10; v++) begin
      en = tbl[v].en; mode = tbl[v].mode;
      for (int h = 0; h < tbl[v].hold; h++) begin
        cyc();
        check("tbl_leds", longint'(leds4), longint'(tbl[v].leds));
        check("tbl_strobe", longint'(stb4), longint'(h == tbl[v].hold - 1));
        if (seen5.size() == 0 || seen5[$] != leds5) seen5.push_back(leds5);
      end
    end
    for (int i = 0; i < 9; i++)
      check("scan5_seq", (seen5.size() > i) ? longint'(seen5[i]) : -1,
            longint'(scan5_exp[i]));
    $display("seq: fill/bounce table and N=5 scan sequence done");

    // en low mid-step (divider=2) freezes everything; resume needs 2 more cycles
    mode = 2'd0; en = 1'b1;
    do_reset();
    cyc(); cyc();
    en = 1'b0;
    held = leds4;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("freeze_leds", longint'(leds4), longint'(held));
      check("freeze_stb", longint'(stb4), 0);
    end
    en = 1'b1;
    cyc(); check("resume_stb1", longint'(stb4), 0);
    cyc(); check("resume_stb2", longint'(stb4), 1);
    cyc(); check("resume_leds", longint'(leds4), 64'b1100);
    $display("seq: enable freeze/resume done");

    // Mode 1 -> 3 on the same cycle as a tick
    mode = 2'd1; en = 1'b1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      cyc();
      if (stb4) found = 1'b1;
    end
    check("wait_strobe", longint'(found), 1);
    cyc(); cyc(); cyc();
    mode = 2'd3;
    cyc(); check("mchg_stb_e1", longint'(stb4), 0);
    cyc(); check("mchg_leds_e2", longint'(leds4), 64'b0000);
    check("mchg_stb_e2", longint'(stb4), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); check("mchg_leds_hold", longint'(leds4), 64'b0000);
    end
    cyc(); check("mchg_leds_e6", longint'(leds4), 64'b1111);
    $display("seq: mode change on tick done");

    // Asynchronous reset between edges while a strobe is high
    mode = 2'd1; en = 1'b1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      cyc();
      if (stb4) found = 1'b1;
    end
    check("wait_strobe2", longint'(found), 1);
    #3;
    rst_n = 1'b0;
    m4 = model_reset(4);
    m5 = model_reset(5);
    #1;
    check("async_leds4", longint'(leds4), 64'hF);
    check("async_stb4", longint'(stb4), 0);
    check("async_leds5", longint'(leds5), 64'h1F);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("seq: asynchronous reset done");

    // Randomized run against the model
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) mode  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) mode5 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) do_reset();
      cyc();
    end
    $display("seq: random run done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
